// File: rtl/sst_pkg.sv
// Save-state sequencer shared definitions.
// Holds the FSM state encoding, the fixed mapper addresses that the
// readback decoders also rely on, and the stream length helper.
package sst_pkg;

  // Address whose readback is the mapper index (stream header).
  localparam int unsigned SST_HDR_ADDR = 127;
  // Default last restorable register address.
  localparam int unsigned SST_LAST_DEF = 126;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SET   = 3'd1,
    ST_RD_PUSH  = 3'd2,
    ST_HDR_PULL = 3'd3,
    ST_HDR_CHK  = 3'd4,
    ST_LD_PULL  = 3'd5,
    ST_LD_WR    = 3'd6,
    ST_FIN      = 3'd7
  } sst_st_t;

  // Header byte plus one byte per address 0..last_addr.
  function automatic int unsigned sst_stream_len(input int unsigned last_addr);
    return last_addr + 2;
  endfunction

endpackage

// File: rtl/sst_if.sv
// Mapper save-state bus.
//   act    : bus active, freezes normal mapper register updates
//   addr   : register address
//   we_reg : register write request (committed by the mapper on m3)
//   dato   : write data
//   di     : mapper readback, combinational from addr
// master = sequencer side, slave = mapper side.
interface sst_if;
  logic       act;
  logic [7:0] addr;
  logic       we_reg;
  logic [7:0] dato;
  logic [7:0] di;

  modport master (output act, output addr, output we_reg, output dato, input di);
  modport slave  (input act, input addr, input we_reg, input dato, output di);
endinterface

// File: rtl/sst_wr_gate.sv
// Write gate: holds a pending mapper write until the next m3 strobe.
//   clk, map_rst_n : clock, synchronous active-low reset
//   arm_i          : start a pending write (from the load FSM)
//   kill_i         : drop any pending write immediately (abort)
//   m3_i           : CPU-cycle strobe, the mapper commits on it
//   pend_o         : write request level, drives sst_we_reg
//   wr_done_o      : the clock on which the mapper commits
module sst_wr_gate (
  input  logic clk,
  input  logic map_rst_n,
  input  logic arm_i,
  input  logic kill_i,
  input  logic m3_i,
  output logic pend_o,
  output logic wr_done_o
);

  logic pend_q, pend_d;

  assign wr_done_o = pend_q & m3_i;
  assign pend_o    = pend_q;

  // Request drops on the clock after the committing m3, so it can never
  // span two m3 pulses.
  always_comb begin
    pend_d = pend_q;
    if (kill_i)         pend_d = 1'b0;
    else if (wr_done_o) pend_d = 1'b0;
    else if (arm_i)     pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!map_rst_n) pend_q <= 1'b0;
    else            pend_q <= pend_d;
  end

endmodule

// File: rtl/sst_seq.sv
// Save-state sequencer: initiator of the mapper save-state bus.
// SAVE streams header + registers 0..SST_LAST out on so_*; LOAD takes the
// same format from li_*, checks the header against the mapper index and
// writes the registers back, one per m3 strobe.
//   clk, map_rst_n          : clock, synchronous active-low reset
//   m3                      : CPU-cycle strobe
//   cmd_save, cmd_load      : start pulses (save wins if both)
//   abort                   : cancel, sets err
//   busy, done, err         : status
//   so_dat/so_valid/so_ready: save stream out
//   li_dat/li_valid/li_ready: load stream in
//   sst                     : mapper save-state bus
//
// state    | meaning
// IDLE     | waiting for a command
// RD_SET   | address driven, waiting for readback to settle
// RD_PUSH  | byte offered on save stream
// HDR_PULL | waiting for load header byte
// HDR_CHK  | settle, then compare header with mapper index
// LD_PULL  | waiting for next load data byte
// LD_WR    | write pending until m3 commits it
// FIN      | one clock of wrap-up (done pulse on success)
module sst_seq
  import sst_pkg::*;
#(
  parameter int unsigned SST_LAST  = SST_LAST_DEF,
  parameter int unsigned HDR_ADDR  = SST_HDR_ADDR,
  parameter int unsigned RD_SETTLE = 1
) (
  input  logic       clk,
  input  logic       map_rst_n,
  input  logic       m3,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] so_dat,
  output logic       so_valid,
  input  logic       so_ready,
  input  logic [7:0] li_dat,
  input  logic       li_valid,
  output logic       li_ready,
  sst_if.master      sst
);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_RD_SET   = ST_RD_SET;
  localparam logic [2:0] S_RD_PUSH  = ST_RD_PUSH;
  localparam logic [2:0] S_HDR_PULL = ST_HDR_PULL;
  localparam logic [2:0] S_HDR_CHK  = ST_HDR_CHK;
  localparam logic [2:0] S_LD_PULL  = ST_LD_PULL;
  localparam logic [2:0] S_LD_WR    = ST_LD_WR;
  localparam logic [2:0] S_FIN      = ST_FIN;

  localparam logic [7:0] A_HDR     = 8'(HDR_ADDR);
  localparam logic [7:0] A_LAST    = 8'(SST_LAST);
  localparam logic [1:0] SETTLE_LD = 2'(RD_SETTLE - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] settle_q, settle_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       so_valid_q, so_valid_d, act_q, act_d;
  logic [7:0] so_dat_q, so_dat_d, addr_q, addr_d, dato_q, dato_d, hdr_q, hdr_d;
  logic       arm_wr, wr_pend, wr_done;

  sst_wr_gate u_wr_gate (
    .clk       (clk),
    .map_rst_n (map_rst_n),
    .arm_i     (arm_wr),
    .kill_i    (abort),
    .m3_i      (m3),
    .pend_o    (wr_pend),
    .wr_done_o (wr_done)
  );

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    so_valid_d = so_valid_q;
    so_dat_d   = so_dat_q;
    act_d      = act_q;
    addr_d     = addr_q;
    dato_d     = dato_q;
    hdr_d      = hdr_q;
    arm_wr     = 1'b0;
    if (abort) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      act_d      = 1'b0;
      so_valid_d = 1'b0;
      err_d      = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_save || cmd_load) begin
          addr_d   = A_HDR;
          act_d    = 1'b1;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          settle_d = SETTLE_LD;
          state_d  = cmd_save ? S_RD_SET : S_HDR_PULL;
        end
        S_RD_SET: begin
          if (settle_q == 2'd0) begin
            so_dat_d   = sst.di;
            so_valid_d = 1'b1;
            state_d    = S_RD_PUSH;
          end else begin
            settle_d = settle_q - 2'd1;
          end
        end
        S_RD_PUSH: if (so_ready) begin
          so_valid_d = 1'b0;
          settle_d   = SETTLE_LD;
          state_d    = S_RD_SET;
          // Header goes first, then the ascending sweep.
          if (addr_q == A_HDR) begin
            addr_d = 8'd0;
          end else if (addr_q == A_LAST) begin
            act_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            addr_d = addr_q + 8'd1;
          end
        end
        S_HDR_PULL: if (li_valid) begin
          hdr_d    = li_dat;
          settle_d = SETTLE_LD;
          state_d  = S_HDR_CHK;
        end
        S_HDR_CHK: begin
          if (settle_q != 2'd0) begin
            settle_d = settle_q - 2'd1;
          end else if (hdr_q != sst.di) begin
            err_d   = 1'b1;
            act_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            addr_d  = 8'd0;
            state_d = S_LD_PULL;
          end
        end
        S_LD_PULL: if (li_valid) begin
          dato_d  = li_dat;
          arm_wr  = 1'b1;
          state_d = S_LD_WR;
        end
        S_LD_WR: if (wr_done) begin
          if (addr_q == A_LAST) begin
            act_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_LD_PULL;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!map_rst_n) begin
      state_q    <= S_IDLE;
      settle_q   <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      so_valid_q <= 1'b0;
      so_dat_q   <= 8'd0;
      act_q      <= 1'b0;
      addr_q     <= 8'd0;
      dato_q     <= 8'd0;
      hdr_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      so_valid_q <= so_valid_d;
      so_dat_q   <= so_dat_d;
      act_q      <= act_d;
      addr_q     <= addr_d;
      dato_q     <= dato_d;
      hdr_q      <= hdr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign so_valid   = so_valid_q;
  assign so_dat     = so_dat_q;
  assign li_ready   = (state_q == S_HDR_PULL) || (state_q == S_LD_PULL);
  assign sst.act    = act_q;
  assign sst.addr   = addr_q;
  assign sst.we_reg = wr_pend;
  assign sst.dato   = dato_q;

endmodule

// File: tb/tb_sst_seq.sv
// Bench for the save-state sequencer with a 128-byte mapper model.
module tb_sst_seq;
  import sst_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       map_rst_n, cmd_save, cmd_load, abort, so_ready, li_valid;
  logic       m3 = 1'b0;
  logic [7:0] li_dat;
  logic       busy, done, err, so_valid, li_ready;
  logic [7:0] so_dat;

  sst_if bus ();

  sst_seq #(.SST_LAST(SST_LAST_DEF), .HDR_ADDR(SST_HDR_ADDR), .RD_SETTLE(1)) dut (
    .clk(clk), .map_rst_n(map_rst_n), .m3(m3), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .abort(abort), .busy(busy), .done(done), .err(err), .so_dat(so_dat), .so_valid(so_valid),
    .so_ready(so_ready), .li_dat(li_dat), .li_valid(li_valid), .li_ready(li_ready), .sst(bus)
  );

  // Mapper model: readback is combinational, writes commit on we_reg & m3.
  logic [7:0] mem [128];
  logic       preload = 1'b1;
  int         commits = 0;
  assign bus.di = mem[bus.addr[6:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 127; i++) mem[i] <= 8'(i) ^ 8'hA5;
      mem[127] <= 8'h5A;
    end else if (bus.we_reg && m3) begin
      mem[bus.addr[6:0]] <= bus.dato;
      commits <= commits + 1;
    end
  end

  // m3: one-clock strobe every 12 clocks, changes just after posedge.
  int m3_cnt = 0;
  always @(posedge clk) begin
    #2;
    m3_cnt = (m3_cnt == 11) ? 0 : m3_cnt + 1;
    m3 = (m3_cnt == 11);
  end

  int n_run = 0, n_fail = 0;
  logic [7:0] exp_mem [128];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_so_valid"}, so_valid, 0);
    check({tag, "_li_ready"}, li_ready, 0);
    check({tag, "_act"}, bus.act, 0);
    check({tag, "_we"}, bus.we_reg, 0);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_dato"}, bus.dato, 0);
    check({tag, "_so_dat"}, so_dat, 0);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 128; i++) check($sformatf("%s_mem%0d", tag, i), mem[i], exp_mem[i]);
  endtask

  task automatic run_save(input bit toggle);
    logic [7:0] q[$];
    logic [7:0] held, exp;
    bit stalled = 0, done_seen = 0;
    int we_cnt = 0, stall_cnt = 0, cyc = 0;
    q.push_back(exp_mem[127]);
    for (int i = 0; i < 127; i++) q.push_back(exp_mem[i]);
    so_ready = 1'b1;
    cmd_save = 1'b1;
    @(negedge clk);
    cmd_save = 1'b0;
    check("save_busy", busy, 1);
    check("save_err_clr", err, 0);
    while (!done_seen && cyc < 3000) begin
      so_ready = toggle ? (cyc % 4) >= 2 : 1'b1;
      if (bus.we_reg) we_cnt++;
      if (done) done_seen = 1;
      if (stalled && so_valid) check("save_hold", so_dat, held);
      stalled = 0;
      if (so_valid && so_ready) begin
        exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
        check("save_byte", so_dat, exp);
      end else if (so_valid) begin
        stalled = 1;
        held = so_dat;
        stall_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    check("save_done", done_seen, 1);
    check("save_left", q.size(), 0);
    check("save_we", we_cnt, 0);
    if (toggle) check("save_stalls", stall_cnt > 0, 1);
    @(negedge clk);
    check("save_idle_busy", busy, 0);
    check("save_idle_act", bus.act, 0);
  endtask

  // mode 0: run to completion, 1: abort at stop_at, 2: reset at stop_at
  task automatic run_load(input string tag, input logic [7:0] hdr, input logic [7:0] key,
                          input int mode, input int stop_at, output bit done_seen,
                          output int we_cnt, output int n_commit);
    logic [7:0] tx[$];
    int c0, cyc;
    bit finished;
    c0 = commits; cyc = 0; finished = 0; done_seen = 0; we_cnt = 0;
    tx.push_back(hdr);
    for (int i = 0; i < 127; i++) tx.push_back(8'(i) ^ key);
    cmd_load = 1'b1;
    @(negedge clk);
    cmd_load = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_err_clr"}, err, 0);
    while (!finished && cyc < 5000) begin
      li_valid = tx.size() > 0;
      li_dat   = (tx.size() > 0) ? tx[0] : 8'h00;
      if (done) done_seen = 1;
      if (bus.we_reg) we_cnt++;
      if (mode != 0 && bus.we_reg && bus.addr == 8'(stop_at) && !m3) begin
        if (mode == 1) abort = 1'b1; else map_rst_n = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        li_valid = 1'b0;
        if (mode == 1) begin
          check({tag, "_busy"}, busy, 0);
          check({tag, "_act"}, bus.act, 0);
          check({tag, "_we"}, bus.we_reg, 0);
          check({tag, "_li_ready"}, li_ready, 0);
          check({tag, "_so_valid"}, so_valid, 0);
          check({tag, "_err"}, err, 1);
          check({tag, "_done"}, done, 0);
        end else begin
          check_all_zero(tag);
          map_rst_n = 1'b1;
        end
        finished = 1;
      end else begin
        if (li_valid && li_ready) void'(tx.pop_front());
        if (!busy) finished = 1;
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_finished"}, finished, 1);
    li_valid = 1'b0;
    repeat (3) begin
      if (done) done_seen = 1;
      @(negedge clk);
    end
    check({tag, "_act_end"}, bus.act, 0);
    n_commit = commits - c0;
  endtask

  bit ld_done;
  int ld_we, ld_commit;

  initial begin
    map_rst_n = 1'b0; cmd_save = 1'b0; cmd_load = 1'b0; abort = 1'b0;
    so_ready = 1'b0; li_valid = 1'b0; li_dat = 8'h00;
    for (int i = 0; i < 127; i++) exp_mem[i] = 8'(i) ^ 8'hA5;
    exp_mem[127] = 8'h5A;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    check_all_zero("rst");
    map_rst_n = 1'b1;
    @(negedge clk);

    run_save(1'b0);
    run_save(1'b1);

    run_load("ld_ok", 8'h5A, 8'h00, 0, 0, ld_done, ld_we, ld_commit);
    for (int i = 0; i < 127; i++) exp_mem[i] = 8'(i);
    check("ld_ok_done", ld_done, 1);
    check("ld_ok_err", err, 0);
    check("ld_ok_commits", ld_commit, 127);
    check_mem("ld_ok");

    run_load("ld_bad", 8'h5B, 8'h00, 0, 0, ld_done, ld_we, ld_commit);
    check("ld_bad_done", ld_done, 0);
    check("ld_bad_err", err, 1);
    check("ld_bad_we", ld_we, 0);
    check("ld_bad_commits", ld_commit, 0);
    check_mem("ld_bad");

    run_load("ld_abort", 8'h5A, 8'h3C, 1, 40, ld_done, ld_we, ld_commit);
    for (int i = 0; i < 40; i++) exp_mem[i] = 8'(i) ^ 8'h3C;
    check("ld_abort_done", ld_done, 0);
    check("ld_abort_commits", ld_commit, 40);
    check_mem("ld_abort");

    run_save(1'b0);

    run_load("ld_rst", 8'h5A, 8'h77, 2, 10, ld_done, ld_we, ld_commit);
    for (int i = 0; i < 10; i++) exp_mem[i] = 8'(i) ^ 8'h77;
    check("ld_rst_done", ld_done, 0);
    check("ld_rst_commits", ld_commit, 10);
    check_mem("ld_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sst_seq.md
Name: sst_seq

Overview:
- Save-state sequencer: the initiator end of the mapper save-state bus (act / addr / we_reg / dato out, di back).
- SAVE: sweeps the mapper's state-register space and streams each byte out to the host-side save buffer.
- LOAD: pulls bytes from the host stream and writes them back into the mapper, gated on a mapper-index header check.
- Sits between the host save/restore controller and the active mapper; one instance per system.

Parameters:
- SST_LAST, 126: last restorable register address. Addresses 0..SST_LAST are swept.
- HDR_ADDR, 127: address whose read value is the mapper index, used as the stream header.
- RD_SETTLE, 1: clocks to wait after an address change before sampling sst_di (range 1..3).

Ports:
- clk  in  1  system clock
- map_rst_n  in  1  synchronous active-low reset
- m3  in  1  one-clock CPU-cycle strobe; the mapper only commits sst writes on this pulse
- cmd_save  in  1  start SAVE pulse; ignored while busy
- cmd_load  in  1  start LOAD pulse; ignored while busy
- abort  in  1  cancel the current operation
- busy  out  1  operation in progress
- done  out  1  one-clock pulse on successful completion
- err  out  1  sticky error flag; cleared on the next accepted command
- so_dat  out  8  save stream data
- so_valid  out  1  save stream valid
- so_ready  in  1  save stream ready
- li_dat  in  8  load stream data
- li_valid  in  1  load stream valid
- li_ready  out  1  load stream ready
- sst_act  out  1  save-state bus active; freezes normal mapper register updates
- sst_addr  out  8  register address
- sst_we_reg  out  1  register write request
- sst_dato  out  8  write data
- sst_di  in  8  mapper readback (combinational from sst_addr)

Behaviour:
- Reset (map_rst_n=0 sampled at a clk edge):
  - State goes to IDLE.
  - Every output is 0: busy, done, err, so_valid, li_ready, sst_act, sst_we_reg, sst_addr, sst_dato, so_dat.
  - Reset mid-operation abandons the operation immediately. No partial write is retried.
- Handshakes: a stream byte transfers on a clock where valid&ready=1. so_dat is held stable while so_valid=1 and so_ready=0.
- Stream format, both directions: byte 0 = header (value read at HDR_ADDR), then the bytes for addresses 0..SST_LAST in ascending order. Total SST_LAST+2 bytes.
- States: IDLE, RD_SET, RD_PUSH, HDR_PULL, HDR_CHK, LD_PULL, LD_WR, FIN.
- IDLE:
  - cmd_save → sst_addr=HDR_ADDR, sst_act=1, busy=1, err=0, go to RD_SET.
  - cmd_load → sst_addr=HDR_ADDR, sst_act=1, busy=1, err=0, go to HDR_PULL.
  - If both commands arrive on the same clock, SAVE wins.
- SAVE path:
  - RD_SET: wait RD_SETTLE clocks, then capture so_dat←sst_di, assert so_valid, go to RD_PUSH.
  - RD_PUSH: on transfer, deassert so_valid.
    - If sst_addr was HDR_ADDR, set sst_addr=0.
    - Else if sst_addr==SST_LAST, go to FIN.
    - Else increment sst_addr.
    - Return to RD_SET unless going to FIN.
- LOAD path:
  - HDR_PULL: li_ready=1. On transfer, latch the byte and go to HDR_CHK.
  - HDR_CHK: wait RD_SETTLE clocks, then compare the latched byte with sst_di.
    - Mismatch: err=1, go to FIN with no done pulse. No writes have been issued.
    - Match: sst_addr=0, go to LD_PULL.
  - LD_PULL: li_ready=1. On transfer, sst_dato←li_dat, sst_we_reg=1, go to LD_WR.
  - LD_WR: hold sst_addr, sst_dato and sst_we_reg=1 until the first clock with m3=1 (the mapper commits on that clock).
    - On the next clock drop sst_we_reg.
    - If sst_addr==SST_LAST, go to FIN; else increment sst_addr and return to LD_PULL.
    - Minimum one full m3 period per byte. sst_we_reg is never high on two consecutive m3 pulses for different addresses.
- FIN: sst_act=0, busy=0, done=1 for one clock (only on success), then IDLE.
- abort: takes priority over everything except reset. Next clock: state IDLE, sst_we_reg=0, sst_act=0, so_valid=0, li_ready=0, err=1.
  - abort coincident with m3 in LD_WR: that write is committed by the mapper. The sequencer still aborts.
- li_ready is asserted only in HDR_PULL and LD_PULL.
- Stream stalls (so_ready=0, li_valid=0) wait indefinitely. sst_act stays 1 throughout.
- sst_addr is 8-bit and never wraps: the terminal compare against SST_LAST ends the sweep.

Decomposition:
- Shared package sst_pkg:
  - state enum sst_st_t;
  - constants SST_HDR_ADDR=127 and SST_LAST_DEF=126, shared with the mapper readback decoders;
  - stream length function.
- Sub-module sst_wr_gate: holds a pending write until m3, then emits wr_done. Isolates the m3 timing from the main FSM.

Test Plan:
- Model mapper (128-byte reg file, di=mem[addr], addr127=8'h5A), memory preloaded with addr^8'hA5, cmd_save with so_ready=1 → stream 5A,A5,A4,…,DB (127 bytes after the header), then done pulse, busy=0, no sst_we_reg seen.
- Save with so_ready toggled 1/0 every other clock → identical byte sequence; so_dat stable during every stall.
- cmd_load with stream 5A then 127 bytes 00..7E, m3 every 12 clocks → model mem[i]=i for i≤126, mem[127] untouched, exactly 127 write commits, done pulse.
- cmd_load with header 5B → err=1, no done, zero sst_we_reg assertions, sst_act=0 afterwards.
- abort asserted during LD_WR at addr 40 → state IDLE next clock, err=1, mem[41..126] unchanged; then cmd_save accepted and err clears.
- map_rst_n=0 mid-load at addr 10 while sst_we_reg=1 → all outputs 0 next clock; mem[10] not written if reset precedes the m3 pulse.
